// File: rtl/fir_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream FIR between NUM_REQ requesters.
// A source-ID FIFO records grant order so FIR output packets are routed back to their issuer.
module fir_stream_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DIN_W         = 16,
    parameter int unsigned DOUT_W        = 32,
    parameter int unsigned ID_FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ*DIN_W-1:0]   req_tdata,
    input  logic [NUM_REQ-1:0]         req_tvalid,
    input  logic [NUM_REQ-1:0]         req_tlast,
    output logic [NUM_REQ-1:0]         req_tready,
    output logic [DIN_W-1:0]           s_axis_fir_tdata,
    output logic                       s_axis_fir_tvalid,
    output logic                       s_axis_fir_tlast,
    input  logic                       s_axis_fir_tready,
    input  logic [DOUT_W-1:0]          m_axis_fir_tdata,
    input  logic                       m_axis_fir_tvalid,
    input  logic                       m_axis_fir_tlast,
    output logic                       m_axis_fir_tready,
    output logic [NUM_REQ*DOUT_W-1:0]  rsp_tdata,
    output logic [NUM_REQ-1:0]         rsp_tvalid,
    output logic [NUM_REQ-1:0]         rsp_tlast,
    input  logic [NUM_REQ-1:0]         rsp_tready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       orphan_err
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {S_IDLE, S_PASS} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  pick;
    logic             found;
    logic [ID_W-1:0]  id_mem_q [ID_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             orphan_q, orphan_d;
    logic [ID_W-1:0]  head;
    logic             push, pop, fifo_empty, fifo_full;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(ID_FIFO_DEPTH));
    assign head       = id_mem_q[rd_ptr_q];

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_tvalid[ID_W'(idx)]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            orphan_q <= orphan_d;
        end
    end

    // ID storage needs no reset: entries are only read while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem_q[wr_ptr_q] <= pick;
        end
    end

    // Forward-path FSM: grant in IDLE, combinational pass-through in PASS.
    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        rr_ptr_d          = rr_ptr_q;
        push              = 1'b0;
        s_axis_fir_tdata  = '0;
        s_axis_fir_tvalid = 1'b0;
        s_axis_fir_tlast  = 1'b0;
        req_tready        = '0;
        if (!reset) begin
            unique case (state_q)
                S_IDLE: begin
                    if (found && !fifo_full) begin
                        grant_d  = pick;
                        push     = 1'b1;
                        rr_ptr_d = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                        state_d  = S_PASS;
                    end
                end
                S_PASS: begin
                    s_axis_fir_tdata    = req_tdata[grant_q*DIN_W +: DIN_W];
                    s_axis_fir_tvalid   = req_tvalid[grant_q];
                    s_axis_fir_tlast    = req_tlast[grant_q];
                    req_tready[grant_q] = s_axis_fir_tready;
                    if (s_axis_fir_tvalid && s_axis_fir_tready && s_axis_fir_tlast) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Return path: route FIR output to the FIFO head, flag output with no owner.
    always_comb begin
        rsp_tdata         = '0;
        rsp_tvalid        = '0;
        rsp_tlast         = '0;
        m_axis_fir_tready = 1'b0;
        pop               = 1'b0;
        orphan_d          = orphan_q;
        if (!reset) begin
            if (!fifo_empty) begin
                rsp_tdata[head*DOUT_W +: DOUT_W] = m_axis_fir_tdata;
                rsp_tvalid[head]                 = m_axis_fir_tvalid;
                rsp_tlast[head]                  = m_axis_fir_tlast;
                m_axis_fir_tready                = rsp_tready[head];
                pop = m_axis_fir_tvalid && rsp_tready[head] && m_axis_fir_tlast;
            end else if (m_axis_fir_tvalid) begin
                orphan_d = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(ID_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(ID_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    assign grant_id   = grant_q;
    assign busy       = (state_q == S_PASS);
    assign orphan_err = orphan_q;

endmodule

// File: tb/tb_fir_stream_arbiter.sv
// Directed bench for fir_stream_arbiter: requester sources, a y=2x FIR model with
// 4-cycle latency, and per-requester sinks, all driven on negedge and sampled on posedge.
module tb_fir_stream_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned OW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*DW-1:0]  req_tdata;
    logic [NR-1:0]     req_tvalid, req_tlast, req_tready;
    logic [DW-1:0]     s_axis_fir_tdata;
    logic              s_axis_fir_tvalid, s_axis_fir_tlast, s_axis_fir_tready;
    logic [OW-1:0]     m_axis_fir_tdata;
    logic              m_axis_fir_tvalid, m_axis_fir_tlast, m_axis_fir_tready;
    logic [NR*OW-1:0]  rsp_tdata;
    logic [NR-1:0]     rsp_tvalid, rsp_tlast, rsp_tready;
    logic [1:0]        grant_id;
    logic              busy, orphan_err;

    always #5 clk = ~clk;

    fir_stream_arbiter #(
        .NUM_REQ(NR), .DIN_W(DW), .DOUT_W(OW), .ID_FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tlast(req_tlast),
        .req_tready(req_tready),
        .s_axis_fir_tdata(s_axis_fir_tdata), .s_axis_fir_tvalid(s_axis_fir_tvalid),
        .s_axis_fir_tlast(s_axis_fir_tlast), .s_axis_fir_tready(s_axis_fir_tready),
        .m_axis_fir_tdata(m_axis_fir_tdata), .m_axis_fir_tvalid(m_axis_fir_tvalid),
        .m_axis_fir_tlast(m_axis_fir_tlast), .m_axis_fir_tready(m_axis_fir_tready),
        .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tlast(rsp_tlast),
        .rsp_tready(rsp_tready),
        .grant_id(grant_id), .busy(busy), .orphan_err(orphan_err)
    );

    typedef struct {
        logic [OW-1:0] d;
        logic          l;
        int            t;
    } fbeat_t;

    fbeat_t      fq[$];
    logic [DW:0] rmem [NR][16];
    int          rhead [NR];
    int          rtail [NR];
    logic [OW:0] rxmem [NR][64];
    int          rxn [NR];
    int          rxb [NR];
    logic [DW:0] fin_log[$];
    int          glog[$];
    int          fb, gb;
    int          cyc, viol, glast;
    logic        prev_busy;
    logic        fir_rdy, toggle_mode, orph_drive;
    logic [NR-1:0] rsp_rdy;
    int          checks, failures;

    // Source, FIR-output and sink drivers.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (rhead[i] != rtail[i]) begin
                req_tvalid[i] = 1'b1;
                {req_tlast[i], req_tdata[i*DW +: DW]} = rmem[i][rhead[i] % 16];
            end else begin
                req_tvalid[i] = 1'b0;
                req_tlast[i]  = 1'b0;
                req_tdata[i*DW +: DW] = '0;
            end
        end
        s_axis_fir_tready = toggle_mode ? ((cyc % 2) == 0) : fir_rdy;
        if (fq.size() > 0 && fq[0].t <= cyc) begin
            m_axis_fir_tvalid = 1'b1;
            m_axis_fir_tdata  = fq[0].d;
            m_axis_fir_tlast  = fq[0].l;
        end else begin
            m_axis_fir_tvalid = orph_drive;
            m_axis_fir_tdata  = '0;
            m_axis_fir_tlast  = 1'b0;
        end
        rsp_tready = rsp_rdy;
    end

    // Handshake bookkeeping, FIR model and protocol monitor.
    always @(posedge clk) begin
        logic signed [OW-1:0] x;
        logic [NR-1:0]        gmask;
        cyc++;
        if (reset) begin
            fq.delete();
            prev_busy = 1'b0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (req_tvalid[i] && req_tready[i]) rhead[i]++;
            end
            if (m_axis_fir_tvalid && m_axis_fir_tready && fq.size() > 0) void'(fq.pop_front());
            if (s_axis_fir_tvalid && s_axis_fir_tready) begin
                x = OW'(signed'(s_axis_fir_tdata));
                fq.push_back('{x * 2, s_axis_fir_tlast, cyc + 4});
                fin_log.push_back({s_axis_fir_tlast, s_axis_fir_tdata});
            end
            for (int i = 0; i < NR; i++) begin
                if (rsp_tvalid[i] && rsp_tready[i]) begin
                    rxmem[i][rxn[i] % 64] = {rsp_tlast[i], rsp_tdata[i*OW +: OW]};
                    rxn[i]++;
                end
            end
            gmask = busy ? (NR'(1) << grant_id) : '0;
            if ((req_tready & ~gmask) != '0) viol++;
            if (busy && !prev_busy) begin
                glog.push_back(int'(grant_id));
                glast = int'(grant_id);
            end else if (busy && int'(grant_id) != glast) begin
                viol++;
            end
            prev_busy = busy;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic push_beat(input int r, input logic [DW-1:0] d, input logic l);
        rmem[r][rtail[r] % 16] = {l, d};
        rtail[r]++;
    endtask

    task automatic flush();
        for (int i = 0; i < NR; i++) begin
            rtail[i] = rhead[i];
            rxb[i]   = rxn[i];
        end
        fb = fin_log.size();
        gb = glog.size();
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        tick(n);
        flush();
        reset = 1'b0;
    endtask

    function automatic int vb(input int i, input int p, input int b);
        return i * 16 + p * 4 + b + 1;
    endfunction

    function automatic int rcount(input int i);
        return rxn[i] - rxb[i];
    endfunction

    function automatic logic [OW:0] rx(input int i, input int k);
        return rxmem[i][(rxb[i] + k) % 64];
    endfunction

    function automatic logic [DW:0] fin(input int k);
        return fin_log[fb + k];
    endfunction

    function automatic int ng();
        return glog.size() - gb;
    endfunction

    function automatic int gr(input int k);
        return glog[gb + k];
    endfunction

    logic [DW:0] d_exp [5];

    initial begin
        checks = 0; failures = 0; cyc = 0; viol = 0; glast = 0; prev_busy = 1'b0;
        fb = 0; gb = 0;
        fir_rdy = 1'b1; toggle_mode = 1'b0; orph_drive = 1'b0; rsp_rdy = '1;
        for (int i = 0; i < NR; i++) begin
            rhead[i] = 0; rtail[i] = 0; rxn[i] = 0; rxb[i] = 0;
        end
        reset = 1'b1;

        // Reset state
        tick(3);
        at_neg();
        check_eq("rst_req_tready", 64'(req_tready), 64'(0));
        check_eq("rst_s_tvalid", 64'(s_axis_fir_tvalid), 64'(0));
        check_eq("rst_m_tready", 64'(m_axis_fir_tready), 64'(0));
        check_eq("rst_rsp_tvalid", 64'(rsp_tvalid), 64'(0));
        flush();
        reset = 1'b0;
        at_neg();
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_grant_id", 64'(grant_id), 64'(0));
        check_eq("rst_orphan", 64'(orphan_err), 64'(0));

        // A: requester 1, {100,-5,7}
        push_beat(1, 16'd100, 1'b0);
        push_beat(1, -16'sd5, 1'b0);
        push_beat(1, 16'd7, 1'b1);
        at_neg();
        check_eq("A_lat_idle_tvalid", 64'(s_axis_fir_tvalid), 64'(0));
        at_neg();
        check_eq("A_lat_tvalid", 64'(s_axis_fir_tvalid), 64'(1));
        check_eq("A_lat_tdata", 64'(s_axis_fir_tdata), 64'(100));
        check_eq("A_grant", 64'(grant_id), 64'(1));
        check_eq("A_tready_onehot", 64'(req_tready), 64'(4'b0010));
        tick(20);
        check_eq("A_fir_beats", 64'(fin_log.size() - fb), 64'(3));
        check_eq("A_fir0", 64'(fin(0)), 64'({1'b0, 16'd100}));
        check_eq("A_fir1", 64'(fin(1)), 64'({1'b0, 16'hFFFB}));
        check_eq("A_fir2", 64'(fin(2)), 64'({1'b1, 16'd7}));
        check_eq("A_rsp_count", 64'(rcount(1)), 64'(3));
        check_eq("A_rsp0", 64'(rx(1, 0)), 64'({1'b0, 32'd200}));
        check_eq("A_rsp1", 64'(rx(1, 1)), 64'({1'b0, 32'hFFFF_FFF6}));
        check_eq("A_rsp2", 64'(rx(1, 2)), 64'({1'b1, 32'd14}));
        check_eq("A_other_rsp", 64'(rcount(0) + rcount(2) + rcount(3)), 64'(0));
        check_eq("A_orphan", 64'(orphan_err), 64'(0));

        // B: all four requesters, two 2-beat packets each
        pulse_reset(1);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NR; i++)
                for (int b = 0; b < 2; b++)
                    push_beat(i, 16'(vb(i, p, b)), b == 1);
        tick(50);
        check_eq("B_grants", 64'(ng()), 64'(8));
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("B_grant%0d", k), 64'(gr(k)), 64'(k % 4));
        for (int i = 0; i < NR; i++) begin
            check_eq($sformatf("B_rsp_count%0d", i), 64'(rcount(i)), 64'(4));
            for (int k = 0; k < 4; k++)
                check_eq($sformatf("B_rsp%0d_%0d", i, k), 64'(rx(i, k)),
                         64'({k % 2 == 1, 32'(2 * vb(i, k / 2, k % 2))}));
        end

        // C: responses stalled, five packets requested
        pulse_reset(1);
        rsp_rdy = '0;
        for (int i = 0; i < NR; i++)
            for (int b = 0; b < 2; b++)
                push_beat(i, 16'(vb(i, 0, b)), b == 1);
        for (int b = 0; b < 2; b++) push_beat(0, 16'(vb(0, 1, b)), b == 1);
        tick(30);
        check_eq("C_grants_held", 64'(ng()), 64'(4));
        check_eq("C_busy", 64'(busy), 64'(0));
        check_eq("C_grant_id", 64'(grant_id), 64'(3));
        check_eq("C_no_rsp", 64'(rcount(0) + rcount(1) + rcount(2) + rcount(3)), 64'(0));
        at_neg();
        check_eq("C_rsp_tvalid_head", 64'(rsp_tvalid), 64'(4'b0001));
        check_eq("C_m_tready", 64'(m_axis_fir_tready), 64'(0));
        check_eq("C_req_tready", 64'(req_tready), 64'(0));
        rsp_rdy = '1;
        tick(40);
        check_eq("C_grants_after", 64'(ng()), 64'(5));
        check_eq("C_grant5", 64'(gr(4)), 64'(0));
        check_eq("C_rsp0_count", 64'(rcount(0)), 64'(4));
        check_eq("C_rsp0_last", 64'(rx(0, 3)), 64'({1'b1, 32'd12}));
        check_eq("C_rsp3_count", 64'(rcount(3)), 64'(2));

        // D: FIR ready toggling during a requester-2 packet, requester 3 waiting
        pulse_reset(1);
        toggle_mode = 1'b1;
        push_beat(2, 16'd11, 1'b0);
        push_beat(2, 16'd22, 1'b0);
        push_beat(2, 16'd33, 1'b0);
        push_beat(2, 16'd44, 1'b1);
        push_beat(3, 16'd55, 1'b1);
        tick(40);
        toggle_mode = 1'b0;
        d_exp[0] = {1'b0, 16'd11};
        d_exp[1] = {1'b0, 16'd22};
        d_exp[2] = {1'b0, 16'd33};
        d_exp[3] = {1'b1, 16'd44};
        d_exp[4] = {1'b1, 16'd55};
        check_eq("D_fir_beats", 64'(fin_log.size() - fb), 64'(5));
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("D_fir%0d", k), 64'(fin(k)), 64'(d_exp[k]));
        check_eq("D_grants", 64'(ng()), 64'(2));
        check_eq("D_grant0", 64'(gr(0)), 64'(2));
        check_eq("D_grant1", 64'(gr(1)), 64'(3));
        check_eq("D_rsp2_count", 64'(rcount(2)), 64'(4));
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("D_rsp2_%0d", k), 64'(rx(2, k)),
                     64'({k == 3, 32'(22 * (k + 1))}));
        check_eq("D_rsp3", 64'(rx(3, 0)), 64'({1'b1, 32'd110}));

        // E: reset in the middle of a requester-3 packet
        pulse_reset(1);
        for (int b = 0; b < 6; b++) push_beat(3, 16'(b + 1), b == 5);
        tick(3);
        check_eq("E_busy_mid", 64'(busy), 64'(1));
        check_eq("E_grant_mid", 64'(grant_id), 64'(3));
        check_eq("E_beats_mid", 64'(fin_log.size() - fb), 64'(2));
        reset = 1'b1;
        at_neg();
        check_eq("E_rst_req_tready", 64'(req_tready), 64'(0));
        check_eq("E_rst_s_tvalid", 64'(s_axis_fir_tvalid), 64'(0));
        check_eq("E_rst_m_tready", 64'(m_axis_fir_tready), 64'(0));
        check_eq("E_rst_rsp_tvalid", 64'(rsp_tvalid), 64'(0));
        tick(1);
        flush();
        reset = 1'b0;
        at_neg();
        check_eq("E_post_busy", 64'(busy), 64'(0));
        check_eq("E_post_grant", 64'(grant_id), 64'(0));
        check_eq("E_post_s_tvalid", 64'(s_axis_fir_tvalid), 64'(0));
        check_eq("E_post_m_tready", 64'(m_axis_fir_tready), 64'(0));
        push_beat(1, 16'd70, 1'b0);
        push_beat(1, 16'd71, 1'b1);
        push_beat(0, 16'd80, 1'b0);
        push_beat(0, 16'd81, 1'b1);
        tick(20);
        check_eq("E_grants", 64'(ng()), 64'(2));
        check_eq("E_grant0", 64'(gr(0)), 64'(0));
        check_eq("E_grant1", 64'(gr(1)), 64'(1));
        check_eq("E_rsp0", 64'(rx(0, 1)), 64'({1'b1, 32'd162}));
        check_eq("E_rsp1", 64'(rx(1, 1)), 64'({1'b1, 32'd142}));
        check_eq("E_orphan", 64'(orphan_err), 64'(0));

        // E2: reset during a requester-1 packet restores requester-0 priority
        pulse_reset(1);
        for (int b = 0; b < 3; b++) push_beat(1, 16'(b + 1), b == 2);
        tick(3);
        pulse_reset(1);
        push_beat(2, 16'd5, 1'b1);
        push_beat(0, 16'd6, 1'b1);
        tick(15);
        check_eq("E2_grant0", 64'(gr(0)), 64'(0));
        check_eq("E2_grant1", 64'(gr(1)), 64'(2));

        // F: FIR output with no packet outstanding
        pulse_reset(1);
        orph_drive = 1'b1;
        at_neg();
        check_eq("F_m_tready", 64'(m_axis_fir_tready), 64'(0));
        check_eq("F_rsp_tvalid", 64'(rsp_tvalid), 64'(0));
        check_eq("F_orphan_pre", 64'(orphan_err), 64'(0));
        tick(1);
        check_eq("F_orphan_set", 64'(orphan_err), 64'(1));
        orph_drive = 1'b0;
        tick(5);
        check_eq("F_orphan_sticky", 64'(orphan_err), 64'(1));
        push_beat(0, 16'd9, 1'b1);
        tick(15);
        check_eq("F_rsp_count", 64'(rcount(0)), 64'(1));
        check_eq("F_rsp", 64'(rx(0, 0)), 64'({1'b1, 32'd18}));
        check_eq("F_orphan_still", 64'(orphan_err), 64'(1));
        pulse_reset(1);
        at_neg();
        check_eq("F_orphan_cleared", 64'(orphan_err), 64'(0));

        check_eq("protocol_violations", 64'(viol), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_stream_arbiter.md
Name: fir_stream_arbiter

Overview:
Shares one AXI-Stream FIR filter instance between NUM_REQ requester streams. Arbitration is round-robin at packet granularity: a grant is held from the first beat to the tlast beat. A source-ID FIFO records the packet order so FIR output packets can be routed back to the requester that issued them. The block sits between the requester-side stream sources/sinks and the FIR's s_axis_fir_* and m_axis_fir_* ports.

Parameters:
NUM_REQ, 4, number of requester streams (2..8)
DIN_W, 16, input sample width (signed)
DOUT_W, 32, FIR output sample width (signed)
ID_FIFO_DEPTH, 4, packets in flight through the FIR (power of 2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
req_tdata  in  NUM_REQ*DIN_W  requester samples; slice i = [i*DIN_W +: DIN_W]
req_tvalid  in  NUM_REQ  per-requester valid
req_tlast  in  NUM_REQ  per-requester end of packet
req_tready  out  NUM_REQ  per-requester ready
s_axis_fir_tdata  out  DIN_W  sample to FIR
s_axis_fir_tvalid  out  1  valid to FIR
s_axis_fir_tlast  out  1  last to FIR
s_axis_fir_tready  in  1  FIR ready to take data
m_axis_fir_tdata  in  DOUT_W  FIR output sample
m_axis_fir_tvalid  in  1  FIR output valid
m_axis_fir_tlast  in  1  FIR output last
m_axis_fir_tready  out  1  arbiter ready for FIR output
rsp_tdata  out  NUM_REQ*DOUT_W  routed output; slice i = [i*DOUT_W +: DOUT_W]
rsp_tvalid  out  NUM_REQ  per-requester output valid
rsp_tlast  out  NUM_REQ  per-requester output last
rsp_tready  in  NUM_REQ  per-requester sink ready
grant_id  out  $clog2(NUM_REQ)  current or last granted requester
busy  out  1  1 in PASS state
orphan_err  out  1  sticky: FIR output arrived with ID FIFO empty

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE, ID FIFO empty, rr_ptr=0 so requester 0 has top priority first, grant_id=0, orphan_err=0. All valids and readies are 0 during reset. Reset mid-packet aborts the packet: the partial packet in the FIR is not tracked and responses are not completed.
- FSM IDLE:
  - If any req_tvalid=1 and the ID FIFO is not full, pick the first i with req_tvalid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - Register grant_id=i, push i into the ID FIFO, set rr_ptr=(i+1)%NUM_REQ, go to PASS.
  - If the FIFO is full, stay in IDLE.
  - No forward signal is asserted in IDLE.
- FSM PASS:
  - Combinational pass-through: s_axis_fir_tdata/tvalid/tlast = requester[grant_id]; req_tready[grant_id] = s_axis_fir_tready; all other req_tready = 0.
  - On a beat with s_axis_fir_tvalid & s_axis_fir_tready & s_axis_fir_tlast, go to IDLE.
  - Minimum one IDLE bubble cycle between packets.
- Grant latency: first forwarded beat is presented 1 cycle after IDLE samples a valid request.
- Return path:
  - If the ID FIFO is non-empty with head=h: rsp_tdata[h], rsp_tvalid[h], rsp_tlast[h] come from m_axis_fir_*; m_axis_fir_tready = rsp_tready[h]. All other rsp_tvalid = 0.
  - A handshake with m_axis_fir_tlast=1 pops the FIFO.
  - If the FIFO is empty: m_axis_fir_tready=0. If m_axis_fir_tvalid=1, orphan_err is set and held until reset.
  - Zero added latency on the return path.
- Simultaneous push (IDLE grant) and pop (last output beat) in one cycle: both take effect and the count is unchanged. A push while full cannot occur because the grant is blocked.
- rsp_tdata slices of non-selected requesters are driven 0.
- Data is passed unmodified with no width change. Signedness is preserved by the wiring only.
- Single-beat packets (tlast on the first beat) are legal: IDLE→PASS→IDLE.

Test Plan:
- Single requester 1, 3-beat packet {100,-5,7}, FIR model y=2x with 4-cycle latency -> FIR sees exactly those 3 beats with tlast on 7. rsp[1] gets {200,-10,14} with tlast on the last beat. orphan_err=0.
- All 4 requesters valid continuously, 2-beat packets -> grant order 0,1,2,3,0. req_tready is never high for a non-granted requester. Every response packet lands on its originating requester.
- FIR output stalled (rsp_tready=0) with 5 packets requested -> exactly 4 grants, then the arbiter holds in IDLE. Releasing rsp_tready pops the FIFO and the 5th grant follows.
- s_axis_fir_tready toggling 1010 mid-packet on requester 2 -> no beat lost or duplicated, and the grant does not switch before tlast.
- Assert reset for 1 cycle in the middle of a packet from requester 3 -> next cycle all outputs 0 and the FIFO is empty. A new request from requester 1 is granted with rr_ptr=0 priority (requester 0 is preferred if it is also valid).
- Drive m_axis_fir_tvalid=1 with the FIFO empty -> m_axis_fir_tready=0, orphan_err=1 and stays 1 until reset.
